// File: rtl/latch_load_ctrl.sv
// rtl/latch_load_ctrl.sv - serial-to-parallel loader driving a D latch bank with a setup/enable/hold sequence
// Optional even-parity check on each word is built when LATCH_PARITY_EN is defined.
module latch_load_ctrl #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_d,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [WIDTH-1:0] d,
    output logic             e,
    output logic             load_done
`ifdef LATCH_PARITY_EN
    ,
    output logic             par_err
`endif
);

`ifdef LATCH_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = WIDTH + PAR;
    // The shift register keeps only the bits still needed once the final bit arrives.
    localparam int SW    = WIDTH - 1 + PAR;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
    localparam logic [7:0]    EN_LAST  = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SHIFT,
        S_SETUP,
        S_ENABLE,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        en_cnt_q, en_cnt_d;
    logic [SW-1:0]     shreg_q, shreg_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              e_q, e_d;
    logic              ser_ready_q, ser_ready_d;
    logic              load_done_q, load_done_d;
    logic [SW:0]       shifted;
    logic              accept;
`ifdef LATCH_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    assign accept  = ser_valid && ser_ready_q;
    assign shifted = {shreg_q, ser_d};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        en_cnt_d = en_cnt_q;
        shreg_d  = shreg_q;
        d_d      = d_q;
`ifdef LATCH_PARITY_EN
        par_err_d = 1'b0;
`endif
        case (state_q)
            S_SHIFT: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shreg_d = '0;
`ifdef LATCH_PARITY_EN
                        // Data bits plus even parity must XOR to zero.
                        if (^shifted) begin
                            par_err_d = 1'b1;
                        end else begin
                            d_d     = shreg_q;
                            state_d = S_SETUP;
                        end
`else
                        d_d     = shifted;
                        state_d = S_SETUP;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shreg_d = shifted[SW-1:0];
                    end
                end
            end
            S_SETUP: begin
                en_cnt_d = 8'd0;
                state_d  = S_ENABLE;
            end
            S_ENABLE: begin
                if (en_cnt_q == EN_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    en_cnt_d = en_cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                state_d = S_SHIFT;
            end
            default: begin
                state_d = S_SHIFT;
            end
        endcase

        // Outputs are registered images of the next state.
        ser_ready_d = (state_d == S_SHIFT);
        e_d         = (state_d == S_ENABLE);
        load_done_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SHIFT;
            cnt_q       <= '0;
            en_cnt_q    <= 8'd0;
            shreg_q     <= '0;
            d_q         <= '0;
            e_q         <= 1'b0;
            ser_ready_q <= 1'b1;
            load_done_q <= 1'b0;
`ifdef LATCH_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_cnt_q    <= en_cnt_d;
            shreg_q     <= shreg_d;
            d_q         <= d_d;
            e_q         <= e_d;
            ser_ready_q <= ser_ready_d;
            load_done_q <= load_done_d;
`ifdef LATCH_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign d         = d_q;
    assign e         = e_q;
    assign ser_ready = ser_ready_q;
    assign load_done = load_done_q;
`ifdef LATCH_PARITY_EN
    assign par_err   = par_err_q;
`endif

endmodule
